// File: rtl/pulse_cdc_sched.sv
// pulse_cdc_sched
// Round-robin scheduler in front of a shared fast-to-slow pulse synchronizer.
// Event strobes from NUM_REQ sources are counted per source (saturating).
// One pulse is launched at a time. Each launch is followed by GAP forced idle
// cycles so that the slow domain can resolve every pulse.
//
// Ports
//   sys_clk      in   fast-domain clock, rising edge
//   sys_rst      in   asynchronous active-high reset
//   req_pulse    in   [NUM_REQ]  per-source event strobe, one event per high sample
//   enable       in   gates the start of new launches (sampled only in IDLE)
//   clr_ovf      in   clears all overflow flags (a same-cycle set wins)
//   launch       out  one-cycle registered pulse to the shared channel
//   launch_id    out  [ID_W]  source index of the launch; holds between launches
//   pending_any  out  any per-source counter nonzero
//   busy         out  FSM in LAUNCH or GAP
//   overflow     out  [NUM_REQ]  sticky: an event was lost to counter saturation
//   o_dbg_state  out  [2]  current FSM state (IDLE=0, LAUNCH=1, GAP=2)
//
// Channel protocol: there is no back-pressure. launch is a single-cycle strobe
// and launch_id is valid only while launch=1. Successive launch rising edges
// are always at least GAP+2 cycles apart.
module pulse_cdc_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 4,
   parameter int GAP     = 8
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [NUM_REQ-1:0]         req_pulse,
   input  logic                       enable,
   input  logic                       clr_ovf,
   output logic                       launch,
   output logic [$clog2(NUM_REQ)-1:0] launch_id,
   output logic                       pending_any,
   output logic                       busy,
   output logic [NUM_REQ-1:0]         overflow,
   output logic [1:0]                 o_dbg_state
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int GAP_W = $clog2(GAP + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_start;
   logic               r_launch;
   logic [ID_W-1:0]    r_launch_id;
   logic [ID_W-1:0]    r_ptr;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [CNT_W-1:0]   r_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] r_ovf;
   logic [NUM_REQ-1:0] w_nz;
   logic [NUM_REQ-1:0] w_dec;
   logic [NUM_REQ-1:0] w_ovf_set;
   logic [ID_W-1:0]    w_grant;
   logic               w_found;
   logic [ID_W:0]      w_sum;

   // Per-source status: nonzero count, decrement (launch of this source),
   // and overflow set (saturated with an increment that is not cancelled).
   always_comb begin
      w_nz      = '0;
      w_dec     = '0;
      w_ovf_set = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_nz[i]      = (r_cnt[i] != '0);
         w_dec[i]     = (r_state == ST_LAUNCH) && (r_launch_id == ID_W'(i));
         w_ovf_set[i] = req_pulse[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX);
      end
   end

   // Round-robin grant: first nonzero counter at or after r_ptr, wrapping.
   // The index is formed with one spare bit so that the wrap is a subtract.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_sum   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         w_sum = {1'b0, r_ptr} + (ID_W+1)'(off);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         end
         if (!w_found && w_nz[w_sum[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_grant = w_sum[ID_W-1:0];
         end
      end
   end

   // FSM state register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state. enable is looked at only in IDLE, so a started launch
   // always runs through LAUNCH and the full GAP.
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable && w_found) begin
               w_next  = ST_LAUNCH;
               w_start = 1'b1;
            end
         end
         ST_LAUNCH: w_next = ST_GAP;
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Launch strobe, tag, pointer and gap timer
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_launch    <= 1'b0;
         r_launch_id <= '0;
         r_ptr       <= '0;
         r_gap_cnt   <= '0;
      end else begin
         r_launch <= w_start;
         if (w_start) begin
            r_launch_id <= w_grant;
         end
         if (r_state == ST_LAUNCH) begin
            r_ptr     <= (r_launch_id == ID_W'(NUM_REQ-1)) ? '0 : r_launch_id + 1'b1;
            r_gap_cnt <= GAP_W'(GAP - 1);
         end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end
      end
   end

   // Pending counters. An event arriving in the same cycle as its own
   // launch cancels the decrement, so no event is ever lost there.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_cnt[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({req_pulse[i], w_dec[i]})
               2'b10: begin
                  if (r_cnt[i] != CNT_MAX) begin
                     r_cnt[i] <= r_cnt[i] + 1'b1;
                  end
               end
               2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
               default: r_cnt[i] <= r_cnt[i];
            endcase
         end
         // Set has priority over clear.
         r_ovf <= (r_ovf & ~{NUM_REQ{clr_ovf}}) | w_ovf_set;
      end
   end

   assign launch      = r_launch;
   assign launch_id   = r_launch_id;
   assign pending_any = |w_nz;
   assign busy        = (r_state != ST_IDLE);
   assign overflow    = r_ovf;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pulse_cdc_sched.sv
// Bench for pulse_cdc_sched (NUM_REQ=4, CNT_W=4, GAP=8).
// A timer/queue reference model predicts every output each cycle. Directed
// scenarios are pinned with hand-computed literals. A randomized phase
// follows the directed ones.
module tb_pulse_cdc_sched;

   localparam int N    = 4;
   localparam int CW   = 4;
   localparam int GAP  = 8;
   localparam int MAXC = 15;

   // ---------------- clock / reset ----------------
   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic [N-1:0] req_pulse = '0;
   logic         enable = 1'b0;
   logic         clr_ovf = 1'b0;
   logic         launch;
   logic [1:0]   launch_id;
   logic         pending_any;
   logic         busy;
   logic [N-1:0] overflow;
   logic [1:0]   dbg_state;

   always #5 sys_clk = ~sys_clk;

   pulse_cdc_sched #(.NUM_REQ(N), .CNT_W(CW), .GAP(GAP)) u_dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .req_pulse  (req_pulse),
      .enable     (enable),
      .clr_ovf    (clr_ovf),
      .launch     (launch),
      .launch_id  (launch_id),
      .pending_any(pending_any),
      .busy       (busy),
      .overflow   (overflow),
      .o_dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   logic [1:0] exp_q[$];
   int         log_id[$];
   int         log_cyc[$];

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
      end
   endfunction

   // ---------------- reference model ----------------
   // m_tb counts remaining busy cycles: GAP+1 in the launch cycle, then down to 0.
   int         m_cnt [N];
   logic [N-1:0] m_ovf;
   int         m_ptr;
   int         m_tb;
   int         m_id;

   function automatic bit m_launch();
      return (m_tb == GAP + 1);
   endfunction

   function automatic bit m_pending();
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ovf = '0;
      m_ptr = 0;
      m_tb  = 0;
      m_id  = 0;
      exp_q.delete();
   endfunction

   function automatic void model_step(input logic [N-1:0] rq, input logic en, input logic clr);
      int dec_i;
      int nxt_tb;
      dec_i  = m_launch() ? m_id : -1;
      nxt_tb = (m_tb > 0) ? m_tb - 1 : 0;
      if (m_tb == 0 && en && m_pending()) begin
         for (int off = 0; off < N; off++) begin
            int j;
            j = (m_ptr + off) % N;
            if (m_cnt[j] != 0) begin
               m_id = j;
               break;
            end
         end
         nxt_tb = GAP + 1;
         exp_q.push_back(2'(m_id));
      end
      if (dec_i >= 0) m_ptr = (dec_i + 1) % N;
      for (int i = 0; i < N; i++) begin
         bit inc;
         bit dec;
         bit set;
         inc = rq[i];
         dec = (i == dec_i);
         set = 1'b0;
         if (inc && !dec) begin
            if (m_cnt[i] == MAXC) set = 1'b1;
            else m_cnt[i] = m_cnt[i] + 1;
         end else if (dec && !inc) begin
            m_cnt[i] = m_cnt[i] - 1;
         end
         if (set) m_ovf[i] = 1'b1;
         else if (clr) m_ovf[i] = 1'b0;
      end
      m_tb = nxt_tb;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input logic [N-1:0] rq, input logic en, input logic clr);
      req_pulse = rq;
      enable    = en;
      clr_ovf   = clr;
      @(posedge sys_clk);
      if (sys_rst) m_reset();
      else model_step(rq, en, clr);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n, input logic en);
      for (int k = 0; k < n; k++) step('0, en, 1'b0);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      m_reset();
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      sys_rst = 1'b0;
   endtask

   // ---------------- compare process / scoreboard ----------------
   always @(negedge sys_clk) begin
      if (chk_en) begin
         chk("launch", launch, m_launch());
         chk("busy", busy, (m_tb > 0));
         chk("pending_any", pending_any, m_pending());
         chk("overflow", overflow, m_ovf);
         chk("launch_id", launch_id, m_id);
         if (launch === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL sb_underrun got=launch exp=none cyc=%0d", cyc);
            end else begin
               chk("sb_id", launch_id, exp_q.pop_front());
            end
         end
      end
      if (launch === 1'b1) begin
         log_id.push_back(int'(launch_id));
         log_cyc.push_back(cyc);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int fair_exp [7];
      int c0;
      logic [N-1:0] rq;
      int lim;
      fair_exp = '{0, 1, 2, 3, 1, 1, 1};

      m_reset();
      step('0, 1'b0, 1'b0);
      chk_en = 1'b1;
      step('0, 1'b0, 1'b0);
      chk("rst_launch", launch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pending", pending_any, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_launch_id", launch_id, 0);
      sys_rst = 1'b0;
      idle(2, 1'b1);

      // Single event
      log_id.delete(); log_cyc.delete();
      step(4'b0001, 1'b1, 1'b0);
      c0 = cyc;
      chk("single_pend", pending_any, 1);
      chk("single_nolaunch", launch, 0);
      step('0, 1'b1, 1'b0);
      chk("single_launch", launch, 1);
      chk("single_id", launch_id, 0);
      step('0, 1'b1, 1'b0);
      chk("single_launch_off", launch, 0);
      chk("single_pend_off", pending_any, 0);
      chk("single_busy", busy, 1);
      idle(12, 1'b1);
      chk("single_n", log_id.size(), 1);
      if (log_cyc.size() > 0) chk("single_lat", log_cyc[0], c0 + 1);

      // Fairness from ptr=0
      do_reset();
      log_id.delete(); log_cyc.delete();
      step(4'b1111, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      idle(85, 1'b1);
      chk("fair_n", log_id.size(), 7);
      for (int i = 0; i < log_id.size() && i < 7; i++) chk("fair_id", log_id[i], fair_exp[i]);
      for (int i = 1; i < log_cyc.size(); i++) chk("fair_gap", log_cyc[i] - log_cyc[i-1], GAP + 2);

      // Saturation and overflow stickiness
      for (int k = 0; k < 16; k++) step(4'b0100, 1'b0, 1'b0);
      chk("sat_ovf", overflow, 4'b0100);
      chk("sat_busy", busy, 0);
      chk("sat_pend", pending_any, 1);
      step(4'b0100, 1'b0, 1'b1);
      chk("sat_set_wins", overflow, 4'b0100);
      step('0, 1'b0, 1'b1);
      chk("sat_clr", overflow, 4'b0000);
      log_id.delete(); log_cyc.delete();
      idle(160, 1'b1);
      chk("sat_drain_n", log_id.size(), 15);
      chk("sat_drained", pending_any, 0);

      // Increment during own LAUNCH
      log_id.delete(); log_cyc.delete();
      step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("simul_launch", launch, 1);
      step(4'b0001, 1'b1, 1'b0);
      chk("simul_pend", pending_any, 1);
      idle(25, 1'b1);
      chk("simul_n", log_id.size(), 2);
      if (log_id.size() == 2) begin
         chk("simul_id0", log_id[0], 0);
         chk("simul_id1", log_id[1], 0);
         chk("simul_gap", log_cyc[1] - log_cyc[0], GAP + 2);
      end

      // Enable gating
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("en_nolaunch", launch, 0);
      chk("en_busy", busy, 0);
      chk("en_pend", pending_any, 1);
      log_id.delete(); log_cyc.delete();
      step('0, 1'b1, 1'b0);
      chk("en_first", launch, 1);
      idle(10, 1'b1);
      chk("en_second", launch, 1);
      idle(30, 1'b0);
      chk("en_stop_n", log_id.size(), 2);
      if (log_cyc.size() == 2) chk("en_gap", log_cyc[1] - log_cyc[0], GAP + 2);
      chk("en_stop_busy", busy, 0);
      chk("en_stop_pend", pending_any, 1);
      idle(15, 1'b1);

      // Asynchronous reset during LAUNCH
      step(4'b0100, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("arst_pre", launch, 1);
      sys_rst = 1'b1;
      m_reset();
      #1;
      chk("arst_launch", launch, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pend", pending_any, 0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      sys_rst = 1'b0;
      log_id.delete(); log_cyc.delete();
      idle(20, 1'b1);
      chk("arst_quiet", log_id.size(), 0);

      // Randomized phases: alternating light and heavy traffic
      for (int p = 0; p < 8; p++) begin
         lim = (p % 2 == 1) ? 3 : 40;
         for (int k = 0; k < 250; k++) begin
            for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, lim) == 0);
            step(rq, ($urandom_range(0, 15) != 0), ($urandom_range(0, 31) == 0));
         end
      end
      idle(700, 1'b1);
      chk("final_pend", pending_any, 0);
      chk("final_sb_left", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_cdc_sched.md
# pulse_cdc_sched

Round-robin scheduler that shares one fast-to-slow pulse-crossing channel between NUM_REQ event sources in the fast domain. Each source's single-cycle event strobes are counted, not dropped, while the channel is busy. The scheduler launches one pulse at a time, spaced so the slow domain can resolve each one, and tags each pulse with the source index. It sits in the fast clock domain, directly in front of the shared pulse synchronizer's input.

## Interface
- NUM_REQ, 4: number of requesters, 2..16; ID_W = clog2(NUM_REQ), derived internally.
- CNT_W, 4: width of each per-requester pending-event counter; saturates at 2^CNT_W-1.
- GAP, 8: idle cycles forced after each launch, ≥1.
  - Integrator sets it to at least 3 slow-clock periods in sys_clk cycles; the block does not check this.
- sys_clk  in  1  fast-domain clock, rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- req_pulse  in  NUM_REQ  per-requester event strobe; each high bit at a sampling edge is one event.
- enable  in  1  when low, no new launch starts; events still accumulate.
- clr_ovf  in  1  clears all overflow flags.
- launch  out  1  one-cycle pulse to the shared channel; driven from a flop.
- launch_id  out  ID_W  requester index; valid only while launch=1, holds last value otherwise.
- pending_any  out  1  high when any pending counter is nonzero.
- busy  out  1  high in LAUNCH or GAP.
- overflow  out  NUM_REQ  sticky per-requester flag: an event was lost to saturation.

## Operation
- Per-requester counter cnt[i] has the following next-value rules:
  - increment only: +1, unless saturated.
  - decrement only (launch of i): -1.
  - both in the same cycle: unchanged.
  - saturated with increment only: hold at max, set overflow[i].
- overflow[i] is sticky and cleared by clr_ovf. If a set and clr_ovf occur in the same cycle, the set wins.
- Round-robin pointer ptr (reset 0): the grant is the first i ≥ ptr (mod NUM_REQ) with cnt[i]≠0. After a launch of i, ptr ← (i+1) mod NUM_REQ.
- FSM states: IDLE, LAUNCH, GAP.
  - IDLE: if enable=1 and pending_any=1, register grant index into launch_id and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH (exactly 1 cycle): launch=1, decrement cnt[launch_id], update ptr, load gap_cnt ← GAP-1, go to GAP.
  - GAP: decrement gap_cnt. When gap_cnt=0, go to IDLE.
- enable is examined only in IDLE. A launch already started always completes LAUNCH and GAP.
- pending_any is the OR of cnt[i]≠0, taken from the registered counters.
- busy = (state≠IDLE).

## Timing
- Reset values: state IDLE, all cnt 0, ptr 0, gap_cnt 0.
  - Outputs: launch 0, launch_id 0, pending_any 0, busy 0, overflow 0.
  - Reset is asynchronous: launch drops immediately even mid-LAUNCH; in-flight and pending events are discarded.
- Latency with the channel idle: event sampled at edge k → cnt=1 after edge k → launch high from edge k+1 to k+2.
- Back-to-back spacing under continuous backlog: launch rising edges exactly GAP+2 cycles apart (1 LAUNCH + GAP + 1 IDLE).
- A req_pulse on the granted requester during its LAUNCH cycle is counted: net change to cnt is 0.
- Wrap-around: a grant at index NUM_REQ-1 sets ptr to 0.
- Every requester with a nonzero count is served within NUM_REQ launches.
- enable falling in GAP: the FSM reaches IDLE and stays there. enable rising in IDLE with a backlog: LAUNCH at the next edge.

## Test plan
- Single event: req_pulse=4'b0001 for one cycle, channel idle → launch high exactly 1 cycle, 1 cycle after the count update, launch_id=0; cnt[0] returns to 0; pending_any falls.
- Fairness: GAP=8; req_pulse=4'b1111 for one cycle, then req[1] pulses 3 more times → launch_id sequence 0,1,2,3,1,1,1; rising edges 10 cycles apart; no requester is starved.
- Saturation: CNT_W=4, enable=0, 16 pulses on req[2] → cnt[2]=15, overflow[2]=1. Then clr_ovf together with a 17th pulse → overflow stays 1. clr_ovf alone → overflow clears.
- Simultaneous increment and decrement: req[0] pulses during its own LAUNCH cycle → cnt[0] unchanged, one further launch for requester 0 follows GAP+2 cycles later.
- Enable gating: enable=0 with 3 events pending → no launch, pending_any=1, busy=0. enable→1 → first launch at the next edge, then launches at GAP+2 spacing. enable→0 mid-GAP → the current GAP completes, then no further launch.
- Reset mid-operation: assert sys_rst during LAUNCH → launch, busy, and pending_any go to 0 asynchronously. After release, no launch occurs until a new req_pulse.
